tl_cntr_param: RTL
==================

# tl_cntr_param

Parametrised multi-approach traffic-light controller. It generalises the two-road straight/left-turn controller to `N_DIR` approaches. Each approach gets a straight phase and an optional left-turn phase, sized by cycle-count parameters for minimum green, maximum green and yellow. A left phase is skipped when no left demand was latched, and a maximum-green timeout prevents a busy approach from starving the others. It sits directly under the intersection top level, and its sensor inputs are driven straight from the testbench or the sensor front end.

## Interface
Parameters:
- `N_DIR`, 2: number of approaches served round-robin; legal range 2..8.
- `MIN_GREEN`, 2: minimum green cycles for both straight and left phases; must be ≥1.
- `MAX_GREEN`, 8: green cycle limit regardless of demand; must be ≥ `MIN_GREEN`.
- `YELLOW`, 2: yellow cycles; must be ≥1.

Ports:
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `Ts` input `N_DIR`: straight-traffic sensor per approach; bit d belongs to approach d.
- `Tl` input `N_DIR`: left-turn sensor per approach.
- `Ls` output 2·`N_DIR`: straight light; approach d uses bits [2d+1:2d].
- `Ll` output 2·`N_DIR`: left-arrow light; same packing as `Ls`.
- `cur_dir` output clog2(`N_DIR`): index of the approach being served.
- `cur_phase` output 2: current phase; SG=0, SY=1, LG=2, LY=3.

## Operation
- Light encoding: GREEN=2'b00, YELLOW=2'b01, RED=2'b10. 2'b11 is never driven.
- Only approach `cur_dir` is non-red, and only on the light of its active phase. Every other light is RED.
- State is (`cur_dir`, `cur_phase`, `timer`, `lreq[N_DIR-1:0]`).
  - `timer` is clog2(`MAX_GREEN`+1) bits wide.
  - `timer` clears to 0 on every phase entry and increments once per cycle within a phase.
- Transitions, evaluated on the rising edge using the current-cycle inputs:
  - SG → SY when (`timer` ≥ `MIN_GREEN`−1 and !`Ts[cur_dir]`) or `timer` == `MAX_GREEN`−1.
  - SY, when `timer` == `YELLOW`−1:
    - → LG if `lreq[cur_dir]` or `Tl[cur_dir]` is set.
    - otherwise → SG of (`cur_dir`+1) mod `N_DIR`.
  - LG → LY when (`timer` ≥ `MIN_GREEN`−1 and !`Tl[cur_dir]`) or `timer` == `MAX_GREEN`−1.
  - LY → SG of (`cur_dir`+1) mod `N_DIR` when `timer` == `YELLOW`−1.
- Left request latch:
  - `lreq[d]` sets on any edge where `Tl[d]`=1 while d is not in LG or LY.
  - `lreq[d]` clears on the edge entering LG for d.
  - If set and clear coincide, clear wins.
- Sensor changes mid-phase only matter at the exit comparisons; once yellow starts it always runs its full `YELLOW` cycles.
- Direction index wrap: `N_DIR`−1 → 0.

## Timing
Reset values (asynchronous):
- `cur_dir`=0, `cur_phase`=SG, `timer`=0, `lreq`=0.
- `Ls[1:0]`=GREEN; all other `Ls` fields and all `Ll` fields RED.

Timing rules:
- Outputs are registered decodes of state. A light changes in the same cycle `cur_phase` changes, with no extra latency.
- Green duration is `MIN_GREEN`..`MAX_GREEN` cycles. Yellow duration is exactly `YELLOW` cycles.
- Asserting `reset` mid-phase returns to the reset state immediately and discards latched requests.

## Structure
- Shared package `tl_pkg` holds:
  - light encodings GREEN/YELLOW/RED;
  - the phase enum SG/SY/LG/LY;
  - a `next_dir` function for the wrap-around.
- One sub-module, `tl_phase_timer`: the timer with a clear input, plus the min/max/yellow compare flags.
- The FSM and the light decode stay in `tl_cntr_param`.

## Test plan
All scenarios use `N_DIR`=2, `MIN_GREEN`=2, `MAX_GREEN`=6, `YELLOW`=1.

- Reset with all sensors 0:
  - `Ls`=4'b1000 and `Ll`=4'b1010 immediately.
  - Approach 0 SG for 2 cycles, then SY for 1 cycle, then approach 1 SG from cycle 3 (`Ls`=4'b0010).
- `Ts`=2'b01 held high: approach 0 green exactly 6 cycles (max timeout), then yellow, then approach 1 green.
- `Tl[0]` pulsed for one cycle during approach 0 SG:
  - after SY, `cur_phase`=LG and `Ll[1:0]`=GREEN for 2 cycles, then LY for 1 cycle, then approach 1 SG;
  - `lreq[0]` is 0 afterwards.
- `Tl`=0 throughout: no LG or LY ever appears, and phases alternate SG/SY between approaches 0 and 1, wrapping 1→0.
- `Tl[1]`=1 held while approach 1 is in LG: LG lasts 6 cycles and exits via timeout; the set/clear collision leaves `lreq[1]`=0 on LG entry.
- `reset` asserted mid-LY of approach 1, with `Tl[0]` latched earlier: asynchronous return to the reset state, and the latched `lreq` is lost.

Source files
------------

// File: rtl/tl_pkg.sv
// Shared definitions for the parametrised traffic-light controller:
// light encodings, phase enumeration and approach wrap-around helper.
package tl_pkg;

  localparam logic [1:0] LIGHT_GREEN  = 2'b00;
  localparam logic [1:0] LIGHT_YELLOW = 2'b01;
  localparam logic [1:0] LIGHT_RED    = 2'b10;

  typedef enum logic [1:0] {
    SG = 2'd0,
    SY = 2'd1,
    LG = 2'd2,
    LY = 2'd3
  } phase_t;

  function automatic int unsigned next_dir(input int unsigned dir, input int unsigned n_dir);
    return (dir + 1 >= n_dir) ? '0 : dir + 1;
  endfunction

endpackage

// File: rtl/tl_phase_timer.sv
// Per-phase cycle timer: clears on phase entry, counts up once per cycle,
// and flags the minimum-green, maximum-green and yellow-end points.
module tl_phase_timer #(
  parameter int unsigned MIN_GREEN = 2,
  parameter int unsigned MAX_GREEN = 8,
  parameter int unsigned YELLOW    = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic min_ok,
  output logic max_hit,
  output logic yel_done
);

  localparam int unsigned TW = $clog2(MAX_GREEN + 1);
  localparam logic [TW-1:0] MIN_LAST = TW'(MIN_GREEN - 1);
  localparam logic [TW-1:0] MAX_LAST = TW'(MAX_GREEN - 1);
  localparam logic [TW-1:0] YEL_LAST = TW'(YELLOW - 1);

  logic [TW-1:0] timer;

  // Saturating so a stuck count can never wrap back under the exit thresholds.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer <= '0;
    end else if (clr) begin
      timer <= '0;
    end else if (timer != '1) begin
      timer <= timer + TW'(1);
    end
  end

  assign min_ok   = (timer >= MIN_LAST);
  assign max_hit  = (timer == MAX_LAST);
  assign yel_done = (timer == YEL_LAST);

endmodule

// File: rtl/tl_cntr_param.sv
// N-approach round-robin traffic-light controller with straight and optional
// left-turn phases, min/max green limits and latched left-turn requests.
module tl_cntr_param
  import tl_pkg::*;
#(
  parameter int unsigned N_DIR     = 2,
  parameter int unsigned MIN_GREEN = 2,
  parameter int unsigned MAX_GREEN = 8,
  parameter int unsigned YELLOW    = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_DIR-1:0]           Ts,
  input  logic [N_DIR-1:0]           Tl,
  output logic [2*N_DIR-1:0]         Ls,
  output logic [2*N_DIR-1:0]         Ll,
  output logic [$clog2(N_DIR)-1:0]   cur_dir,
  output logic [1:0]                 cur_phase
);

  localparam int unsigned DW = $clog2(N_DIR);
  localparam logic [2*N_DIR-1:0] ALL_RED = {N_DIR{LIGHT_RED}};
  localparam logic [2*N_DIR-1:0] LS_RST  = {ALL_RED[2*N_DIR-1:2], LIGHT_GREEN};

  phase_t             phase, nphase;
  logic [DW-1:0]      ndir, succ;
  logic [N_DIR-1:0]   lreq, nlreq;
  logic [2*N_DIR-1:0] nls, nll;
  logic               go_left, clr;
  logic               min_ok, max_hit, yel_done;

  assign succ      = DW'(next_dir(32'(cur_dir), N_DIR));
  assign cur_phase = phase;
  assign clr       = (nphase != phase);

  tl_phase_timer #(
    .MIN_GREEN (MIN_GREEN),
    .MAX_GREEN (MAX_GREEN),
    .YELLOW    (YELLOW)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clr      (clr),
    .min_ok   (min_ok),
    .max_hit  (max_hit),
    .yel_done (yel_done)
  );

  always_comb begin
    nphase  = phase;
    ndir    = cur_dir;
    go_left = 1'b0;
    unique case (phase)
      SG: if ((min_ok && !Ts[cur_dir]) || max_hit) nphase = SY;
      SY: if (yel_done) begin
        if (lreq[cur_dir] || Tl[cur_dir]) begin
          nphase  = LG;
          go_left = 1'b1;
        end else begin
          nphase = SG;
          ndir   = succ;
        end
      end
      LG: if ((min_ok && !Tl[cur_dir]) || max_hit) nphase = LY;
      LY: if (yel_done) begin
        nphase = SG;
        ndir   = succ;
      end
      default: nphase = SG;
    endcase
  end

  // Clear is applied after set so a request arriving on the LG-entry edge is consumed.
  always_comb begin
    nlreq = lreq;
    for (int unsigned d = 0; d < N_DIR; d++) begin
      if (Tl[d] && !((DW'(d) == cur_dir) && (phase == LG || phase == LY))) nlreq[d] = 1'b1;
    end
    if (go_left) nlreq[cur_dir] = 1'b0;
  end

  // Lights are decoded from next state so they register together with the phase.
  always_comb begin
    nls = ALL_RED;
    nll = ALL_RED;
    unique case (nphase)
      SG: nls[2*ndir +: 2] = LIGHT_GREEN;
      SY: nls[2*ndir +: 2] = LIGHT_YELLOW;
      LG: nll[2*ndir +: 2] = LIGHT_GREEN;
      LY: nll[2*ndir +: 2] = LIGHT_YELLOW;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase   <= SG;
      cur_dir <= '0;
      lreq    <= '0;
      Ls      <= LS_RST;
      Ll      <= ALL_RED;
    end else begin
      phase   <= nphase;
      cur_dir <= ndir;
      lreq    <= nlreq;
      Ls      <= nls;
      Ll      <= nll;
    end
  end

endmodule
